// File: rtl/vga_timing.sv
// Raster timing generator for 640x480 @ 72 Hz: qualifies PLL lock, then runs
// x/y counters with sync, active-video and line/frame strobes, all registered together.
module vga_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 24,
  parameter int H_SYNC    = 40,
  parameter int H_BACK    = 128,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 9,
  parameter int V_SYNC    = 3,
  parameter int V_BACK    = 28,
  parameter int SYNC_NEG  = 1,
  parameter int LOCK_WAIT = 16,
  parameter int CNT_W     = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             locked,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start,
  output logic             running
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int LCW     = $clog2(LOCK_WAIT + 1);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [LCW-1:0]   LOCK_LAST = LCW'(LOCK_WAIT - 1);
  localparam logic             IDLE_SYNC = (SYNC_NEG != 0);

  localparam logic [0:0] WAIT_LOCK = 1'b0;
  localparam logic [0:0] RUN       = 1'b1;

  logic [0:0]       state, state_nx;
  logic [LCW-1:0]   lock_cnt, lock_nx;
  logic [CNT_W-1:0] x_nx, y_nx;
  logic             run_nx, hs_on, vs_on, act_nx;

  always_comb begin
    state_nx = state;
    lock_nx  = lock_cnt;
    x_nx     = '0;
    y_nx     = '0;
    case (state)
      WAIT_LOCK: begin
        if (!locked) begin
          lock_nx = '0;
        end else if (lock_cnt == LOCK_LAST) begin
          state_nx = RUN;
          lock_nx  = '0;
        end else begin
          lock_nx = lock_cnt + LCW'(1);
        end
      end
      default: begin
        if (!locked) begin
          state_nx = WAIT_LOCK;
          lock_nx  = '0;
        end else if (x == H_LAST) begin
          x_nx = '0;
          y_nx = (y == V_LAST) ? '0 : y + CNT_W'(1);
        end else begin
          x_nx = x + CNT_W'(1);
          y_nx = y;
        end
      end
    endcase
  end

  // Decode from the next coordinates so control registers align with x/y.
  assign run_nx = (state_nx == RUN);
  assign hs_on  = run_nx && (x_nx >= HS_BEGIN) && (x_nx < HS_END);
  assign vs_on  = run_nx && (y_nx >= VS_BEGIN) && (y_nx < VS_END);
  assign act_nx = run_nx && (x_nx < H_VIS) && (y_nx < V_VIS);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= WAIT_LOCK;
      lock_cnt    <= '0;
      x           <= '0;
      y           <= '0;
      hsync       <= IDLE_SYNC;
      vsync       <= IDLE_SYNC;
      active      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nx;
      lock_cnt    <= lock_nx;
      x           <= x_nx;
      y           <= y_nx;
      hsync       <= hs_on ^ IDLE_SYNC;
      vsync       <= vs_on ^ IDLE_SYNC;
      active      <= act_nx;
      line_start  <= run_nx && (x_nx == '0);
      frame_start <= run_nx && (x_nx == '0) && (y_nx == '0);
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default-parameter instance and a reduced, active-high
// instance sharing one clock, with per-cycle expected vectors and windowed counts.
module tb_vga_timing;

  localparam int W = 52;
  localparam int K_CLR = 0, K_RUN_A = 1, K_HLOW_A = 2, K_ACT_A = 3, K_LS_A = 4;
  localparam int K_RUN_B = 5, K_FS_B = 6, K_VS_B = 7, K_ACT_B = 8, K_GAP_B = 9;
  localparam int FRAME_A = 832 * 520;
  localparam int FRAME_B = 25 * 12;

  logic clock;
  logic reset_a, locked_a, reset_b, locked_b;
  logic hsync_a, vsync_a, active_a, line_start_a, frame_start_a, running_a;
  logic hsync_b, vsync_b, active_b, line_start_b, frame_start_b, running_b;
  logic [9:0] x_a, y_a, x_b, y_b;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           req_k_q[$];
  int           req_v_q[$];
  string        req_n_q[$];

  int checks = 0;
  int errors = 0;
  int t_a = -1, cnt_a = 0, t_b = -1, cnt_b = 0;
  int c_run_a, c_hlow_a, c_act_a, c_ls_a, c_run_b, c_fs_b, c_vs_b, c_act_b;
  int since_fs_b = 0, gap_b = 0;

  vga_timing dut_a (
    .clock(clock), .reset(reset_a), .locked(locked_a),
    .hsync(hsync_a), .vsync(vsync_a), .active(active_a), .x(x_a), .y(y_a),
    .line_start(line_start_a), .frame_start(frame_start_a), .running(running_a)
  );

  vga_timing #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .SYNC_NEG(0), .LOCK_WAIT(4), .CNT_W(10)
  ) dut_b (
    .clock(clock), .reset(reset_b), .locked(locked_b),
    .hsync(hsync_b), .vsync(vsync_b), .active(active_b), .x(x_b), .y(y_b),
    .line_start(line_start_b), .frame_start(frame_start_b), .running(running_b)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // t is cycles since RUN entry, or -1 when idle
  function automatic logic [25:0] exp_vec(input int t, input int hv, input int hf,
                                          input int hs, input int hb, input int vv,
                                          input int vf, input int vs, input int vb,
                                          input logic neg);
    int ht, xx, yy, vt;
    logic ha, va;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    if (t < 0) return {1'b0, neg, neg, 3'b000, 20'd0};
    xx = t % ht;
    yy = (t / ht) % vt;
    ha = (xx >= hv + hf) && (xx < hv + hf + hs);
    va = (yy >= vv + vf) && (yy < vv + vf + vs);
    return {1'b1, ha ^ neg, va ^ neg, (xx < hv) && (yy < vv), xx == 0,
            (xx == 0) && (yy == 0), 10'(xx), 10'(yy)};
  endfunction

  task automatic model_step(inout int t, inout int cnt, input logic rst, input logic lck,
                            input int lw, input int frame);
    if (rst) begin
      t = -1; cnt = 0;
    end else if (t < 0) begin
      if (!lck) cnt = 0;
      else begin
        cnt++;
        if (cnt == lw) begin t = 0; cnt = 0; end
      end
    end else if (!lck) begin
      t = -1; cnt = 0;
    end else begin
      t = (t + 1) % frame;
    end
  endtask

  // driver: one clock edge per call, expected post-edge outputs queued
  task automatic cyc(input logic r_a, input logic l_a, input logic r_b, input logic l_b,
                     input string nm);
    reset_a = r_a; locked_a = l_a; reset_b = r_b; locked_b = l_b;
    model_step(t_a, cnt_a, r_a, l_a, 16, FRAME_A);
    model_step(t_b, cnt_b, r_b, l_b, 4, FRAME_B);
    exp_q.push_back({exp_vec(t_a, 640, 24, 40, 128, 480, 9, 3, 28, 1'b1),
                     exp_vec(t_b, 16, 2, 3, 4, 6, 2, 2, 2, 1'b0)});
    name_q.push_back(nm);
    @(negedge clock);
  endtask

  task automatic req(input int k, input int v, input string nm);
    req_k_q.push_back(k);
    req_v_q.push_back(v);
    req_n_q.push_back(nm);
  endtask

  // monitor / scoreboard
  initial begin
    logic [W-1:0] got_v, e;
    string nm;
    int k, v, got;
    forever begin
      @(posedge clock);
      #1;
      while (req_k_q.size() > 0) begin
        k = req_k_q.pop_front();
        v = req_v_q.pop_front();
        nm = req_n_q.pop_front();
        if (k == K_CLR) begin
          c_run_a = 0; c_hlow_a = 0; c_act_a = 0; c_ls_a = 0;
          c_run_b = 0; c_fs_b = 0; c_vs_b = 0; c_act_b = 0;
        end else begin
          case (k)
            K_RUN_A:  got = c_run_a;
            K_HLOW_A: got = c_hlow_a;
            K_ACT_A:  got = c_act_a;
            K_LS_A:   got = c_ls_a;
            K_RUN_B:  got = c_run_b;
            K_FS_B:   got = c_fs_b;
            K_VS_B:   got = c_vs_b;
            K_ACT_B:  got = c_act_b;
            default:  got = gap_b;
          endcase
          checks++;
          if (got != v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, v);
          end
        end
      end
      got_v = {running_a, hsync_a, vsync_a, active_a, line_start_a, frame_start_a, x_a, y_a,
               running_b, hsync_b, vsync_b, active_b, line_start_b, frame_start_b, x_b, y_b};
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (got_v !== e) begin
          errors++;
          $display("FAIL %s: got %h, expected %h", nm, got_v, e);
        end
      end
      if (running_a) c_run_a++;
      if (running_a && !hsync_a) c_hlow_a++;
      if (active_a) c_act_a++;
      if (line_start_a) c_ls_a++;
      if (running_b) c_run_b++;
      if (frame_start_b) c_fs_b++;
      if (vsync_b) c_vs_b++;
      if (active_b) c_act_b++;
      since_fs_b++;
      if (frame_start_b) begin
        gap_b = since_fs_b;
        since_fs_b = 0;
      end
    end
  end

  // stimulus
  initial begin
    int guard;
    repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b1, "reset_idle");

    req(K_CLR, 0, "");
    repeat (16) cyc(1'b0, 1'b1, 1'b0, 1'b1, "lock_qualify");
    req(K_RUN_A, 1, "lock_rise_a");
    req(K_RUN_B, 13, "lock_rise_b");

    req(K_CLR, 0, "");
    repeat (832) cyc(1'b0, 1'b1, 1'b0, 1'b1, "line0_a");
    req(K_HLOW_A, 40, "hsync_low_a");
    req(K_ACT_A, 640, "active_a");
    req(K_LS_A, 1, "line_start_a");
    req(K_FS_B, 2, "frame_start_b");
    req(K_VS_B, 145, "vsync_high_b");
    req(K_GAP_B, FRAME_B, "frame_gap_b");

    cyc(1'b0, 1'b0, 1'b0, 1'b1, "lock_loss_a");
    req(K_CLR, 0, "");
    repeat (10) cyc(1'b0, 1'b1, 1'b0, 1'b1, "glitch_pre_a");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "glitch_low_a");
    req(K_RUN_A, 0, "glitch_no_run_a");
    req(K_CLR, 0, "");
    repeat (16) cyc(1'b0, 1'b1, 1'b0, 1'b1, "glitch_requal_a");
    req(K_RUN_A, 1, "glitch_rise_a");

    guard = 0;
    while (t_b != 3 * 25 + 10 && guard < 400) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, "seek_b");
      guard++;
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, "lock_loss_b");
    req(K_CLR, 0, "");
    repeat (4) cyc(1'b0, 1'b1, 1'b0, 1'b1, "relock_b");
    req(K_RUN_B, 1, "relock_rise_b");
    req(K_FS_B, 1, "relock_frame_b");

    guard = 0;
    while (t_b != 8 * 25 + 5 && guard < 400) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, "seek_vsync_b");
      guard++;
    end
    req(K_CLR, 0, "");
    cyc(1'b0, 1'b1, 1'b1, 1'b1, "reset_mid_b");
    req(K_VS_B, 0, "reset_vsync_b");
    req(K_ACT_B, 0, "reset_active_b");
    req(K_RUN_B, 0, "reset_run_b");
    req(K_CLR, 0, "");
    repeat (4) cyc(1'b0, 1'b1, 1'b0, 1'b1, "requal_b");
    req(K_RUN_B, 1, "requal_rise_b");
    req(K_CLR, 0, "");
    repeat (FRAME_B) cyc(1'b0, 1'b1, 1'b0, 1'b1, "frame_b");
    req(K_VS_B, 50, "frame_vsync_b");
    req(K_FS_B, 1, "frame_fs_b");
    req(K_ACT_B, 96, "frame_active_b");
    req(K_GAP_B, FRAME_B, "frame_gap2_b");

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator for the 640x480 @ 72 Hz VGA output, clocked by the 31.5 MHz pixel clock from the PLL stage. It qualifies the PLL lock indication, then runs horizontal and vertical counters that produce sync pulses, the active-video window, pixel coordinates and frame/line strobes. These outputs drive the downstream pixel generator and the VGA connector pins.

## Interface

- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 24, horizontal front porch (pixels)
- H_SYNC, 40, horizontal sync width (pixels)
- H_BACK, 128, horizontal back porch (pixels); line total 832
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 9, vertical front porch (lines)
- V_SYNC, 3, vertical sync width (lines)
- V_BACK, 28, vertical back porch (lines); frame total 520
- SYNC_NEG, 1, 1 = sync pulses active-low, 0 = active-high (applies to both)
- LOCK_WAIT, 16, consecutive cycles of `locked`=1 required before running (≥1)
- CNT_W, 10, counter/coordinate width; must hold line total − 1 and frame total − 1

Ports:
- clock  input  1  31.5 MHz pixel clock (PLL output)
- reset  input  1  synchronous, active-high
- locked  input  1  PLL lock, treated as synchronous to `clock`
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- active  output  1  1 while (x,y) lies in the visible window
- x  output  CNT_W  horizontal counter (pixel column)
- y  output  CNT_W  vertical counter (line)
- line_start  output  1  one-cycle strobe when x = 0 (running only)
- frame_start  output  1  one-cycle strobe when x = 0 and y = 0 (running only)
- running  output  1  1 in RUN state

## Operation

- States: WAIT_LOCK (reset state), RUN.
- WAIT_LOCK: lock counter increments each cycle `locked`=1 and clears on `locked`=0. On the LOCK_WAIT-th consecutive high sample, go to RUN next cycle with x=0, y=0.
- RUN: x increments each cycle. At x = H_total−1, x wraps to 0 and y increments. At y = V_total−1 with x = H_total−1, both wrap to 0.
- RUN with `locked`=0 sampled: go to WAIT_LOCK next cycle. Counters and lock counter clear, and all outputs take their idle values.
- Idle values (reset and WAIT_LOCK): hsync = vsync = inactive level (1 when SYNC_NEG=1), active=0, x=0, y=0, line_start=0, frame_start=0, running=0.
- Sync decoding, in RUN:
  - hsync asserted iff H_VISIBLE+H_FRONT ≤ x < H_VISIBLE+H_FRONT+H_SYNC (defaults 664..703).
  - vsync asserted iff V_VISIBLE+V_FRONT ≤ y < V_VISIBLE+V_FRONT+V_SYNC (defaults 489..491), for whole lines including blanking.
- active = (x < H_VISIBLE) && (y < V_VISIBLE).
- All outputs are registered. In any cycle, hsync/vsync/active/strobes describe exactly the (x,y) presented in the same cycle, so there is no skew between coordinates and control.
- Comparisons are unsigned at CNT_W bits. Counters never exceed their total − 1.

## Timing

- Latency `reset` → idle: outputs at idle values in the cycle after `reset` is sampled high. `reset` overrides `locked`.
- Lock latency: with `locked` high from cycle 0 (first sample at edge 0), running=1 and (x,y)=(0,0), frame_start=1 in cycle LOCK_WAIT.
- A `locked` glitch low during WAIT_LOCK restarts the full LOCK_WAIT count.
- Loss of lock: one-cycle latency to idle. Re-entry always restarts at (0,0) with frame_start.
- Line period H_total = 832 cycles; frame period 832×520 = 432640 cycles; line_start every 832 cycles; frame_start every 432640 cycles.
- Reset mid-frame: idle next cycle, then a full LOCK_WAIT qualification before RUN.

## Test plan

- Reset + lock: `reset` high 3 cycles with `locked`=1, then released → outputs idle; running rises exactly 16 cycles after release; first RUN cycle x=0, y=0, frame_start=1, active=1.
- Lock glitch: `locked` high 10 cycles, low 1, high again → running rises 16 cycles after re-assertion, not earlier.
- Horizontal: in RUN on line 0 → active=1 for x 0..639; hsync low for x 664..703 (40 cycles); x wraps 831→0 with line_start=1, y=1.
- Vertical: run full frame → vsync low for lines 489..491 (3×832 = 2496 cycles); active=0 for y ≥ 480; frame_start pulses exactly 432640 cycles apart.
- Lock loss mid-frame: drop `locked` at x=300, y=200 → next cycle running=0, hsync=vsync=1, x=y=0. Restore `locked` → restart at (0,0) after 16 cycles.
- Reset mid-frame with SYNC_NEG=0: `reset` at y=490 → next cycle hsync=vsync=0 (inactive), active=0. Re-run confirms active-high pulses at the same positions.
